sap_ctrl_seq: RTL and testbench

//  Controller-sequencer for the 8-bit bus machine. Generates the per-T-state control

---
 rtl/sap_ctrl_seq_pkg.sv | 54 +++++
 rtl/sap_ctrl_seq_if.sv | 21 ++
 rtl/sap_ctrl_seq_t_ring.sv | 48 ++++
 rtl/sap_ctrl_seq.sv | 82 ++++++++
 tb/tb_sap_ctrl_seq.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/sap_ctrl_seq_pkg.sv
// Shared constants for the SAP controller-sequencer.
//   - opcode values (IR upper nibble)
//   - T-state bit indices into the one-hot ring
//   - control-word bit positions and width
//   - one-hot ring state encoding
package sap_ctrl_pkg;

  localparam int OP_W     = 4;
  localparam int CON_W    = 12;
  localparam int T_STATES = 6;

  localparam logic [OP_W-1:0] OP_LDA = 4'b0000;
  localparam logic [OP_W-1:0] OP_ADD = 4'b0001;
  localparam logic [OP_W-1:0] OP_SUB = 4'b0010;
  localparam logic [OP_W-1:0] OP_OUT = 4'b1110;
  localparam logic [OP_W-1:0] OP_HLT = 4'b1111;

  localparam int T1 = 0;
  localparam int T2 = 1;
  localparam int T3 = 2;
  localparam int T4 = 3;
  localparam int T5 = 4;
  localparam int T6 = 5;

  localparam int CON_CP = 11;
  localparam int CON_EP = 10;
  localparam int CON_LM = 9;
  localparam int CON_CE = 8;
  localparam int CON_LI = 7;
  localparam int CON_EI = 6;
  localparam int CON_LA = 5;
  localparam int CON_EA = 4;
  localparam int CON_SU = 3;
  localparam int CON_EU = 2;
  localparam int CON_LB = 1;
  localparam int CON_LO = 0;

  typedef enum logic [T_STATES-1:0] {
    S_T1 = 6'b000001,
    S_T2 = 6'b000010,
    S_T3 = 6'b000100,
    S_T4 = 6'b001000,
    S_T5 = 6'b010000,
    S_T6 = 6'b100000
  } ring_e;

  function automatic logic [CON_W-1:0] con_bit(input int idx);
    logic [CON_W-1:0] v;
    v = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/sap_ctrl_seq_if.sv
// Control-side bundle between the sequencer and the rest of the machine.
//   run     : 1 = ring advances, 0 = pause
//   opcode  : IR[7:4], meaningful from T4 onward
//   con     : 12-bit control word
//   hlt     : sticky halt flag
//   t_state : one-hot ring, bit0 = T1
// master drives run/opcode; slave (the sequencer) drives the rest.
interface sap_ctrl_seq_if
  import sap_ctrl_pkg::*;
#(
  parameter int OP_W = 4
);
  logic                run;
  logic [OP_W-1:0]     opcode;
  logic [CON_W-1:0]    con;
  logic                hlt;
  logic [T_STATES-1:0] t_state;

  modport master (output run, output opcode, input con, input hlt, input t_state);
  modport slave  (input run, input opcode, output con, output hlt, output t_state);
endinterface

// File: rtl/sap_ctrl_seq_t_ring.sv
// Six-state one-hot ring counter timing fetch (T1-T3) and execute (T4-T6).
//   clk       : system clock
//   clr       : synchronous active-high reset, forces T1
//   en_i      : advance one state on this edge
//   t_state_o : current one-hot state, bit0 = T1
//
// state | meaning
// S_T1  | fetch: PC onto bus, load MAR
// S_T2  | fetch: increment PC
// S_T3  | fetch: RAM onto bus, load IR
// S_T4  | execute step 1
// S_T5  | execute step 2
// S_T6  | execute step 3, then wrap to T1
module t_ring
  import sap_ctrl_pkg::*;
(
  input  logic                clk,
  input  logic                clr,
  input  logic                en_i,
  output logic [T_STATES-1:0] t_state_o
);

  ring_e state_q, state_d;

  always_ff @(posedge clk) begin
    if (clr) state_q <= S_T1;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (en_i) begin
      case (state_q)
        S_T1:    state_d = S_T2;
        S_T2:    state_d = S_T3;
        S_T3:    state_d = S_T4;
        S_T4:    state_d = S_T5;
        S_T5:    state_d = S_T6;
        S_T6:    state_d = S_T1;
        // a corrupted (non one-hot) ring restarts the instruction
        default: state_d = S_T1;
      endcase
    end
  end

  assign t_state_o = state_q;

endmodule

// File: rtl/sap_ctrl_seq.sv
// Controller-sequencer for the 8-bit bus machine.
//   clk : system clock, all state on rising edge
//   clr : synchronous active-high reset
//   bus : sap_ctrl_seq_if.slave (run, opcode in; con, hlt, t_state out)
// Decodes the ring state and opcode into the control word and owns the
// sticky halt flag. It is the only driver of any bus-enable line.
module sap_ctrl_seq
  import sap_ctrl_pkg::*;
#(
  parameter int OP_W     = 4,
  parameter int T_STATES = 6
)(
  input  logic            clk,
  input  logic            clr,
  sap_ctrl_seq_if.slave   bus
);

  if (T_STATES != 6 || OP_W != 4) begin : g_bad_param
    $error("sap_ctrl_seq supports only T_STATES=6 and OP_W=4");
  end

  logic [5:0]       t_state;
  logic             hlt_q, hlt_d;
  logic             ring_en;
  logic [CON_W-1:0] con_c;

  assign ring_en = bus.run & ~hlt_q;

  t_ring u_ring (
    .clk       (clk),
    .clr       (clr),
    .en_i      (ring_en),
    .t_state_o (t_state)
  );

  // Halt is taken on the edge that ends T4, so the ring lands in T5 and freezes.
  always_comb begin
    hlt_d = hlt_q;
    if (bus.run && t_state[T4] && bus.opcode == OP_HLT) hlt_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (clr) hlt_q <= 1'b0;
    else     hlt_q <= hlt_d;
  end

  always_comb begin
    con_c = '0;
    if (!clr && bus.run && !hlt_q) begin
      if (t_state[T1]) begin
        con_c = con_bit(CON_EP) | con_bit(CON_LM);
      end else if (t_state[T2]) begin
        con_c = con_bit(CON_CP);
      end else if (t_state[T3]) begin
        con_c = con_bit(CON_CE) | con_bit(CON_LI);
      end else if (t_state[T4]) begin
        case (bus.opcode)
          OP_LDA, OP_ADD, OP_SUB: con_c = con_bit(CON_EI) | con_bit(CON_LM);
          OP_OUT:                 con_c = con_bit(CON_EA) | con_bit(CON_LO);
          default:                con_c = '0;
        endcase
      end else if (t_state[T5]) begin
        case (bus.opcode)
          OP_LDA:         con_c = con_bit(CON_CE) | con_bit(CON_LA);
          OP_ADD, OP_SUB: con_c = con_bit(CON_CE) | con_bit(CON_LB);
          default:        con_c = '0;
        endcase
      end else if (t_state[T6]) begin
        case (bus.opcode)
          OP_ADD:  con_c = con_bit(CON_EU) | con_bit(CON_LA);
          OP_SUB:  con_c = con_bit(CON_EU) | con_bit(CON_LA) | con_bit(CON_SU);
          default: con_c = '0;
        endcase
      end
    end
  end

  assign bus.con     = con_c;
  assign bus.hlt     = hlt_q;
  assign bus.t_state = t_state;

endmodule

// File: tb/tb_sap_ctrl_seq.sv
module tb_sap_ctrl_seq;

  logic clk;
  logic clr;

  sap_ctrl_seq_if #(.OP_W(4)) bus_if ();

  sap_ctrl_seq #(.OP_W(4), .T_STATES(6)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model: instruction phase 0..5 and halted flag
  int   m_ph     = 0;
  logic m_halted = 1'b0;

  typedef struct {
    logic        clr;
    logic        run;
    logic [3:0]  op;
    logic [11:0] con;
    logic [5:0]  t;
    logic        hlt;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic c, input logic r, input logic [3:0] op,
                              input logic [11:0] con, input logic [5:0] t, input logic h);
    vec_t v;
    v.clr = c; v.run = r; v.op = op; v.con = con; v.t = t; v.hlt = h;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic c, input logic r, input logic [3:0] op);
    clr = c;
    bus_if.run = r;
    bus_if.opcode = op;
  endtask

  // control word per instruction phase, straight from the instruction table
  function automatic logic [11:0] model_con();
    logic [11:0] fetch [3];
    logic [11:0] ex [3];
    fetch = '{12'h600, 12'h800, 12'h180};
    case (bus_if.opcode)
      4'h0:    ex = '{12'h240, 12'h120, 12'h000};
      4'h1:    ex = '{12'h240, 12'h102, 12'h024};
      4'h2:    ex = '{12'h240, 12'h102, 12'h02C};
      4'hE:    ex = '{12'h011, 12'h000, 12'h000};
      default: ex = '{12'h000, 12'h000, 12'h000};
    endcase
    if (clr || !bus_if.run || m_halted) return 12'h000;
    if (m_ph < 3) return fetch[m_ph];
    return ex[m_ph-3];
  endfunction

  task automatic tick();
    @(posedge clk);
    if (clr) begin
      m_ph = 0;
      m_halted = 1'b0;
    end else if (bus_if.run && !m_halted) begin
      if (m_ph == 3 && bus_if.opcode == 4'hF) m_halted = 1'b1;
      m_ph = (m_ph + 1) % 6;
    end
    #1;
  endtask

  initial begin
    int cp_cnt;
    logic [11:0] c;
    logic [3:0]  legal [6];
    legal = '{4'h0, 4'h1, 4'h2, 4'hE, 4'hF, 4'h5};

    // reset, LDA, ADD (junk opcode during fetch), SUB, OUT, HLT
    add(1,1,4'h0,12'h000,6'h01,0);
    add(1,1,4'h0,12'h000,6'h01,0);
    add(0,1,4'h0,12'h600,6'h01,0);
    add(0,1,4'h0,12'h800,6'h02,0);
    add(0,1,4'h0,12'h180,6'h04,0);
    add(0,1,4'h0,12'h240,6'h08,0);
    add(0,1,4'h0,12'h120,6'h10,0);
    add(0,1,4'h0,12'h000,6'h20,0);
    add(0,1,4'hF,12'h600,6'h01,0);
    add(0,1,4'hF,12'h800,6'h02,0);
    add(0,1,4'hF,12'h180,6'h04,0);
    add(0,1,4'h1,12'h240,6'h08,0);
    add(0,1,4'h1,12'h102,6'h10,0);
    add(0,1,4'h1,12'h024,6'h20,0);
    add(0,1,4'h2,12'h600,6'h01,0);
    add(0,1,4'h2,12'h800,6'h02,0);
    add(0,1,4'h2,12'h180,6'h04,0);
    add(0,1,4'h2,12'h240,6'h08,0);
    add(0,1,4'h2,12'h102,6'h10,0);
    add(0,1,4'h2,12'h02C,6'h20,0);
    add(0,1,4'hE,12'h600,6'h01,0);
    add(0,1,4'hE,12'h800,6'h02,0);
    add(0,1,4'hE,12'h180,6'h04,0);
    add(0,1,4'hE,12'h011,6'h08,0);
    add(0,1,4'hE,12'h000,6'h10,0);
    add(0,1,4'hE,12'h000,6'h20,0);
    add(0,1,4'hF,12'h600,6'h01,0);
    add(0,1,4'hF,12'h800,6'h02,0);
    add(0,1,4'hF,12'h180,6'h04,0);
    add(0,1,4'hF,12'h000,6'h08,0);
    add(0,1,4'hF,12'h000,6'h10,1);

    drive(1, 0, 4'h0);
    tick();

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].clr, vecs[i].run, vecs[i].op);
      #4;
      chk($sformatf("vec%0d_con", i), bus_if.con, vecs[i].con);
      chk($sformatf("vec%0d_t", i), {6'h0, bus_if.t_state}, {6'h0, vecs[i].t});
      chk($sformatf("vec%0d_hlt", i), {11'h0, bus_if.hlt}, {11'h0, vecs[i].hlt});
      tick();
    end

    // halted: ring frozen in T5, nothing asserted regardless of run/opcode
    for (int i = 0; i < 20; i++) begin
      drive(0, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
      #4;
      chk("halt_con", bus_if.con, 12'h000);
      chk("halt_t", {6'h0, bus_if.t_state}, 12'h010);
      chk("halt_hlt", {11'h0, bus_if.hlt}, 12'h001);
      tick();
    end
    drive(1, 1, 4'h0);
    #4;
    chk("halt_clr_con", bus_if.con, 12'h000);
    tick();
    drive(0, 1, 4'h0);
    #4;
    chk("unhalt_con", bus_if.con, 12'h600);
    chk("unhalt_t", {6'h0, bus_if.t_state}, 12'h001);
    chk("unhalt_hlt", {11'h0, bus_if.hlt}, 12'h000);
    tick();

    // pause in T2, then clr during T5 of ADD
    drive(1, 1, 4'h1);
    tick();
    drive(0, 1, 4'h1);
    #4;
    chk("pause_t1_con", bus_if.con, 12'h600);
    tick();
    cp_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      drive(0, 0, 4'h1);
      #4;
      chk("pause_con", bus_if.con, 12'h000);
      chk("pause_t", {6'h0, bus_if.t_state}, 12'h002);
      cp_cnt += int'(bus_if.con[11]);
      tick();
    end
    drive(0, 1, 4'h1);
    #4;
    chk("resume_t2_con", bus_if.con, 12'h800);
    cp_cnt += int'(bus_if.con[11]);
    tick();
    #4;
    chk("resume_t3_con", bus_if.con, 12'h180);
    cp_cnt += int'(bus_if.con[11]);
    tick();
    #4;
    chk("resume_t4_con", bus_if.con, 12'h240);
    tick();
    drive(1, 1, 4'h1);
    #4;
    chk("clr_t5_con", bus_if.con, 12'h000);
    chk("clr_t5_t", {6'h0, bus_if.t_state}, 12'h010);
    tick();
    chk("cp_once", 12'(cp_cnt), 12'h001);
    for (int i = 0; i < 4; i++) begin
      drive(0, 1, 4'h1);
      #4;
      chk("after_clr_t", {6'h0, bus_if.t_state}, 12'(1 << i));
      chk("after_clr_la_lb", bus_if.con & 12'h022, 12'h000);
      tick();
    end

    // randomized run against the model plus structural invariants
    drive(1, 1, 4'h0);
    tick();
    for (int i = 0; i < 10000; i++) begin
      drive(1'($urandom_range(0, 99) < 2), 1'($urandom_range(0, 99) < 80),
            ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : legal[$urandom_range(0, 5)]);
      #4;
      c = bus_if.con;
      chk("rnd_con", c, model_con());
      chk("rnd_t", {6'h0, bus_if.t_state}, 12'(1 << m_ph));
      chk("rnd_hlt", {11'h0, bus_if.hlt}, {11'h0, m_halted});
      chk("rnd_bus_onehot0", 12'($countones({c[10], c[8], c[6], c[4], c[2]}) <= 1), 12'h001);
      chk("rnd_su_eu", 12'(!c[3] || c[2]), 12'h001);
      chk("rnd_t_onehot", 12'($onehot(bus_if.t_state)), 12'h001);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
